// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: program counter, instruction-memory address,
// and the IF/ID pipeline register with redirect, stall and flush handling.
module fetch_stage #(
  parameter int unsigned          D_WIDTH   = 32,
  parameter logic [D_WIDTH-1:0]   RESET_PC  = '0,
  parameter logic [D_WIDTH-1:0]   NOP_INSTR = D_WIDTH'(32'h0000_0013)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               StallF,
  input  logic               StallD,
  input  logic               FlushD,
  input  logic               PCSrcE,
  input  logic [D_WIDTH-1:0] PCTargetE,
  output logic [D_WIDTH-1:0] InstrMemAddr,
  input  logic [D_WIDTH-1:0] InstrMemData,
  output logic [D_WIDTH-1:0] InstrD,
  output logic [D_WIDTH-1:0] PCD,
  output logic [D_WIDTH-1:0] PCPlus4D,
  output logic               ValidD,
  output logic [D_WIDTH-1:0] FetchCount
);

  logic [D_WIDTH-1:0] r_pcf;
  logic [D_WIDTH-1:0] r_instr_d;
  logic [D_WIDTH-1:0] r_pc_d;
  logic [D_WIDTH-1:0] r_pcplus4_d;
  logic               r_valid_d;
  logic [D_WIDTH-1:0] r_fetch_count;

  logic [D_WIDTH-1:0] w_pcplus4f;
  logic [D_WIDTH-1:0] w_target_aligned;
  logic               w_load_d;

  assign w_pcplus4f       = r_pcf + D_WIDTH'(4);
  assign w_target_aligned = {PCTargetE[D_WIDTH-1:2], 2'b00};
  assign w_load_d         = !FlushD && !StallD;

  // Redirect wins over StallF so a taken branch is never lost behind a stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pcf <= RESET_PC;
    end else if (PCSrcE) begin
      r_pcf <= w_target_aligned;
    end else if (!StallF) begin
      r_pcf <= w_pcplus4f;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || FlushD) begin
      r_instr_d   <= NOP_INSTR;
      r_pc_d      <= '0;
      r_pcplus4_d <= '0;
      r_valid_d   <= 1'b0;
    end else if (!StallD) begin
      r_instr_d   <= InstrMemData;
      r_pc_d      <= r_pcf;
      r_pcplus4_d <= w_pcplus4f;
      r_valid_d   <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_count <= '0;
    end else if (w_load_d) begin
      r_fetch_count <= r_fetch_count + D_WIDTH'(1);
    end
  end

  assign InstrMemAddr = r_pcf;
  assign InstrD       = r_instr_d;
  assign PCD          = r_pc_d;
  assign PCPlus4D     = r_pcplus4_d;
  assign ValidD       = r_valid_d;
  assign FetchCount   = r_fetch_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized
// run against a behavioural model of the PC and IF/ID register.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, StallF, StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic [31:0] key;

  logic [31:0] addr_a, data_a, instr_a, pcd_a, p4_a, cnt_a;
  logic        valid_a;
  logic [31:0] addr_b, data_b, instr_b, pcd_b, p4_b, cnt_b;
  logic        valid_b;

  int total = 0;
  int bad   = 0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (32'h0010_0000 + a) ^ key;
  endfunction

  assign data_a = mem(addr_a);
  assign data_b = mem(addr_b);

  fetch_stage dut_a (
    .clk(clk), .rst(rst), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .InstrMemAddr(addr_a),
    .InstrMemData(data_a), .InstrD(instr_a), .PCD(pcd_a), .PCPlus4D(p4_a),
    .ValidD(valid_a), .FetchCount(cnt_a)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_b (
    .clk(clk), .rst(rst), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .InstrMemAddr(addr_b),
    .InstrMemData(data_b), .InstrD(instr_b), .PCD(pcd_b), .PCPlus4D(p4_b),
    .ValidD(valid_b), .FetchCount(cnt_b)
  );

  // Reference model state, one slot per DUT instance.
  logic [31:0] m_pc [2];
  logic [31:0] m_in [2];
  logic [31:0] m_pcd[2];
  logic [31:0] m_p4 [2];
  logic [31:0] m_cnt[2];
  logic        m_v  [2];
  logic [31:0] m_rp [2];

  task automatic idle_inputs();
    StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0; PCTargetE = '0;
  endtask

  // One clock edge: advance the model with the inputs held across the edge,
  // then move to a sampling point 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_in[k] = NOP; m_pcd[k] = 0; m_p4[k] = 0; m_v[k] = 0; m_cnt[k] = 0;
        m_pc[k] = m_rp[k];
      end else begin
        if (FlushD) begin
          m_in[k] = NOP; m_pcd[k] = 0; m_p4[k] = 0; m_v[k] = 0;
        end else if (!StallD) begin
          m_in[k] = mem(m_pc[k]); m_pcd[k] = m_pc[k]; m_p4[k] = m_pc[k] + 4;
          m_v[k] = 1; m_cnt[k] = m_cnt[k] + 1;
        end
        if (PCSrcE) m_pc[k] = PCTargetE & 32'hFFFF_FFFC;
        else if (!StallF) m_pc[k] = m_pc[k] + 4;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1; idle_inputs();
    tick(); tick();
    total++; if (addr_a !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=%h", addr_a, 32'h0); end
    total++; if (instr_a !== NOP) begin bad++; $display("FAIL reset_instr got=%h exp=%h", instr_a, NOP); end
    total++; if (pcd_a !== 32'h0 || p4_a !== 32'h0) begin bad++; $display("FAIL reset_pcd_p4 got=%h/%h exp=0/0", pcd_a, p4_a); end
    total++; if (valid_a !== 1'b0 || cnt_a !== 32'h0) begin bad++; $display("FAIL reset_valid_cnt got=%b/%0d exp=0/0", valid_a, cnt_a); end
    total++; if (addr_b !== 32'hFFFF_FFF8) begin bad++; $display("FAIL reset_addr_b got=%h exp=FFFFFFF8", addr_b); end
  endtask

  task automatic test_straight_line();
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (addr_a !== 32'(4 * (i + 1))) begin bad++; $display("FAIL straight_addr[%0d] got=%h exp=%h", i, addr_a, 32'(4 * (i + 1))); end
      total++; if (instr_a !== 32'h0010_0000 + 32'(4 * i)) begin bad++; $display("FAIL straight_instr[%0d] got=%h exp=%h", i, instr_a, 32'h0010_0000 + 32'(4 * i)); end
      total++; if (pcd_a !== 32'(4 * i) || p4_a !== 32'(4 * i + 4) || valid_a !== 1'b1) begin
        bad++; $display("FAIL straight_pcd[%0d] got=%h/%h/%b exp=%h/%h/1", i, pcd_a, p4_a, valid_a, 32'(4 * i), 32'(4 * i + 4));
      end
    end
    total++; if (cnt_a !== 32'd5) begin bad++; $display("FAIL straight_count got=%0d exp=5", cnt_a); end
  endtask

  task automatic test_load_use_stall();
    rst = 1; tick(); rst = 0;
    repeat (4) tick();
    StallF = 1; StallD = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (addr_a !== 32'h10) begin bad++; $display("FAIL stall_addr[%0d] got=%h exp=00000010", i, addr_a); end
      total++; if (instr_a !== 32'h0010_000C || pcd_a !== 32'hC || p4_a !== 32'h10) begin
        bad++; $display("FAIL stall_ifid[%0d] got=%h/%h/%h exp=0010000c/c/10", i, instr_a, pcd_a, p4_a);
      end
      total++; if (cnt_a !== 32'd4) begin bad++; $display("FAIL stall_count[%0d] got=%0d exp=4", i, cnt_a); end
    end
    idle_inputs();
    tick();
    total++; if (addr_a !== 32'h14 || instr_a !== 32'h0010_0010 || cnt_a !== 32'd5) begin
      bad++; $display("FAIL stall_resume got=%h/%h/%0d exp=14/00100010/5", addr_a, instr_a, cnt_a);
    end
  endtask

  task automatic test_taken_branch();
    repeat (3) tick();
    total++; if (addr_a !== 32'h20) begin bad++; $display("FAIL branch_setup got=%h exp=20", addr_a); end
    PCSrcE = 1; PCTargetE = 32'h40; FlushD = 1;
    tick();
    idle_inputs();
    total++; if (addr_a !== 32'h40) begin bad++; $display("FAIL branch_addr got=%h exp=40", addr_a); end
    total++; if (instr_a !== NOP || valid_a !== 1'b0) begin bad++; $display("FAIL branch_bubble got=%h/%b exp=%h/0", instr_a, valid_a, NOP); end
    tick();
    total++; if (instr_a !== 32'h0010_0040 || pcd_a !== 32'h40 || valid_a !== 1'b1) begin
      bad++; $display("FAIL branch_target got=%h/%h/%b exp=00100040/40/1", instr_a, pcd_a, valid_a);
    end
  endtask

  task automatic test_priority();
    logic [31:0] cnt0;
    cnt0 = cnt_a;
    StallF = 1; StallD = 1; FlushD = 1; PCSrcE = 1; PCTargetE = 32'h80;
    tick();
    total++; if (addr_a !== 32'h80) begin bad++; $display("FAIL prio_addr got=%h exp=80", addr_a); end
    total++; if (instr_a !== NOP || valid_a !== 1'b0 || pcd_a !== 0 || p4_a !== 0) begin
      bad++; $display("FAIL prio_bubble got=%h/%b/%h/%h exp=%h/0/0/0", instr_a, valid_a, pcd_a, p4_a, NOP);
    end
    total++; if (cnt_a !== cnt0) begin bad++; $display("FAIL prio_count got=%0d exp=%0d", cnt_a, cnt0); end
    PCTargetE = 32'h43;
    tick();
    idle_inputs();
    total++; if (addr_a !== 32'h40) begin bad++; $display("FAIL prio_align got=%h exp=40", addr_a); end
  endtask

  task automatic test_wrap();
    rst = 1; idle_inputs(); tick(); rst = 0;
    tick();
    total++; if (addr_b !== 32'hFFFF_FFFC || pcd_b !== 32'hFFFF_FFF8) begin bad++; $display("FAIL wrap_1 got=%h/%h exp=fffffffc/fffffff8", addr_b, pcd_b); end
    tick();
    total++; if (addr_b !== 32'h0 || pcd_b !== 32'hFFFF_FFFC || p4_b !== 32'h0) begin
      bad++; $display("FAIL wrap_2 got=%h/%h/%h exp=0/fffffffc/0", addr_b, pcd_b, p4_b);
    end
    tick();
    total++; if (addr_b !== 32'h4 || pcd_b !== 32'h0 || instr_b !== 32'h0010_0000) begin
      bad++; $display("FAIL wrap_3 got=%h/%h/%h exp=4/0/00100000", addr_b, pcd_b, instr_b);
    end
  endtask

  task automatic test_mid_reset();
    repeat (3) tick();
    StallF = 1; StallD = 1; FlushD = 1; PCSrcE = 1; PCTargetE = 32'h200; rst = 1;
    tick();
    total++; if (addr_a !== 32'h0 || addr_b !== 32'hFFFF_FFF8) begin bad++; $display("FAIL midrst_addr got=%h/%h exp=0/fffffff8", addr_a, addr_b); end
    total++; if (instr_a !== NOP || pcd_a !== 0 || p4_a !== 0 || valid_a !== 0 || cnt_a !== 0) begin
      bad++; $display("FAIL midrst_ifid got=%h/%h/%h/%b/%0d exp=%h/0/0/0/0", instr_a, pcd_a, p4_a, valid_a, cnt_a, NOP);
    end
    rst = 0; idle_inputs();
  endtask

  task automatic test_random();
    logic [31:0] o_addr, o_in, o_pcd, o_p4, o_cnt;
    logic        o_v;
    rst = 1; idle_inputs(); tick(); rst = 0;
    key = $urandom;
    for (int n = 0; n < 400; n++) begin
      rst       = ($urandom_range(0, 63) == 0);
      StallF    = ($urandom_range(0, 3) == 0);
      StallD    = ($urandom_range(0, 3) == 0);
      PCSrcE    = ($urandom_range(0, 7) == 0);
      FlushD    = PCSrcE ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 15) == 0);
      PCTargetE = $urandom;
      tick();
      for (int k = 0; k < 2; k++) begin
        o_addr = k == 0 ? addr_a  : addr_b;
        o_in   = k == 0 ? instr_a : instr_b;
        o_pcd  = k == 0 ? pcd_a   : pcd_b;
        o_p4   = k == 0 ? p4_a    : p4_b;
        o_cnt  = k == 0 ? cnt_a   : cnt_b;
        o_v    = k == 0 ? valid_a : valid_b;
        total++;
        if (o_addr !== m_pc[k] || o_in !== m_in[k] || o_pcd !== m_pcd[k] ||
            o_p4 !== m_p4[k] || o_cnt !== m_cnt[k] || o_v !== m_v[k]) begin
          bad++;
          $display("FAIL random[%0d] dut%0d got pc=%h in=%h pcd=%h p4=%h cnt=%0d v=%b exp pc=%h in=%h pcd=%h p4=%h cnt=%0d v=%b",
                   n, k, o_addr, o_in, o_pcd, o_p4, o_cnt, o_v,
                   m_pc[k], m_in[k], m_pcd[k], m_p4[k], m_cnt[k], m_v[k]);
        end
      end
    end
    rst = 0; idle_inputs(); key = '0;
  endtask

  initial begin
    key = '0;
    m_rp[0] = 32'h0;
    m_rp[1] = 32'hFFFF_FFF8;
    for (int k = 0; k < 2; k++) begin
      m_pc[k] = 0; m_in[k] = 0; m_pcd[k] = 0; m_p4[k] = 0; m_cnt[k] = 0; m_v[k] = 0;
    end
    rst = 1; idle_inputs();
    #2;
    test_reset();
    test_straight_line();
    test_load_use_stall();
    test_taken_branch();
    test_priority();
    test_wrap();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
